// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared bus widths, bus field positions and ALU op indices for the execute stage
package exe_stage_pkg;
  localparam int DS_ES_WD = 137;
  localparam int ES_MS_WD = 71;
  localparam int ES_FWD_WD = 39;
  localparam int DS_PC_LSB = 105;
  localparam int DS_OP_LSB = 93;
  localparam int DS_SRC1_IS_SA = 92;
  localparam int DS_SRC1_IS_PC = 91;
  localparam int DS_SRC2_IS_IMM = 90;
  localparam int DS_SRC2_IS_ZIMM = 89;
  localparam int DS_SRC2_IS_8 = 88;
  localparam int DS_GR_WE = 87;
  localparam int DS_MEM_WE = 86;
  localparam int DS_MEM_RE = 85;
  localparam int DS_DEST_LSB = 80;
  localparam int DS_IMM_LSB = 64;
  localparam int DS_RS_LSB = 32;
  localparam int DS_RT_LSB = 0;
  localparam int MS_MEM_RE = 70;
  localparam int MS_GR_WE = 69;
  localparam int MS_DEST_LSB = 64;
  localparam int MS_RESULT_LSB = 32;
  localparam int MS_PC_LSB = 0;
  localparam int FWD_WR_VALID = 38;
  localparam int FWD_IS_LOAD = 37;
  localparam int FWD_DEST_LSB = 32;
  localparam int FWD_RESULT_LSB = 0;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_SLT = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_SLL = 4;
  localparam int OP_SRL = 5;
  localparam int OP_SRA = 6;
  localparam int OP_LUI = 7;
  localparam int OP_AND = 8;
  localparam int OP_OR = 9;
  localparam int OP_XOR = 10;
  localparam int OP_NOR = 11;
  function automatic logic is_shift(input logic [11:0] op);
    return |op[OP_SRA:OP_SLL];
  endfunction
endpackage

// File: rtl/exe_stage_alu.sv
// alu: one-hot opcode ALU (add sub slt sltu sll srl sra lui and or xor nor); zero opcode gives zero
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] sum, diff, sra_res;
  logic [4:0] sa;
  assign sa = alu_src2[4:0];
  assign sum = alu_src1 + alu_src2;
  assign diff = alu_src1 - alu_src2;
  assign sra_res = $signed(alu_src1) >>> sa;
  assign alu_result = ({32{alu_op[OP_ADD]}} & sum)
                    | ({32{alu_op[OP_SUB]}} & diff)
                    | ({32{alu_op[OP_SLT]}} & {31'b0, $signed(alu_src1) < $signed(alu_src2)})
                    | ({32{alu_op[OP_SLTU]}} & {31'b0, alu_src1 < alu_src2})
                    | ({32{alu_op[OP_SLL]}} & (alu_src1 << sa))
                    | ({32{alu_op[OP_SRL]}} & (alu_src1 >> sa))
                    | ({32{alu_op[OP_SRA]}} & sra_res)
                    | ({32{alu_op[OP_LUI]}} & {alu_src1[15:0], 16'b0})
                    | ({32{alu_op[OP_AND]}} & (alu_src1 & alu_src2))
                    | ({32{alu_op[OP_OR]}} & (alu_src1 | alu_src2))
                    | ({32{alu_op[OP_XOR]}} & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[OP_NOR]}} & ~(alu_src1 | alu_src2));
endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage (handshake, operand select, data-SRAM request); ES_FWD_EN adds es_fwd_bus
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DS_TO_ES_BUS_WD = DS_ES_WD,
  parameter int ES_TO_MS_BUS_WD = ES_MS_WD
`ifdef ES_FWD_EN
  , parameter int ES_FWD_BUS_WD = ES_FWD_WD
`endif
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_to_es_valid,
  output logic                       es_allowin,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  input  logic                       es_flush,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
`ifdef ES_FWD_EN
  , output logic [ES_FWD_BUS_WD-1:0] es_fwd_bus
`endif
);
  logic es_valid, es_ready_go, shift;
  logic [DS_TO_ES_BUS_WD-1:0] bus_r;
  logic [31:0] pc, rs_value, rt_value, alu_src1, alu_src2, alu_result;
  logic [11:0] alu_op;
  logic [15:0] imm;
  logic [4:0] dest;
  logic src1_is_sa, src1_is_pc, src2_is_imm, src2_is_zimm, src2_is_8, gr_we, mem_we, mem_re;
  assign pc = bus_r[DS_PC_LSB +: 32];
  assign alu_op = bus_r[DS_OP_LSB +: 12];
  assign src1_is_sa = bus_r[DS_SRC1_IS_SA];
  assign src1_is_pc = bus_r[DS_SRC1_IS_PC];
  assign src2_is_imm = bus_r[DS_SRC2_IS_IMM];
  assign src2_is_zimm = bus_r[DS_SRC2_IS_ZIMM];
  assign src2_is_8 = bus_r[DS_SRC2_IS_8];
  assign gr_we = bus_r[DS_GR_WE];
  assign mem_we = bus_r[DS_MEM_WE];
  assign mem_re = bus_r[DS_MEM_RE];
  assign dest = bus_r[DS_DEST_LSB +: 5];
  assign imm = bus_r[DS_IMM_LSB +: 16];
  assign rs_value = bus_r[DS_RS_LSB +: 32];
  assign rt_value = bus_r[DS_RT_LSB +: 32];
  assign es_ready_go = 1'b1;
  assign es_allowin = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go && !es_flush;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) es_valid <= 1'b0;
    else if (es_flush) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) bus_r <= '0;
    else if (ds_to_es_valid && es_allowin && !es_flush) bus_r <= ds_to_es_bus;
  assign shift = is_shift(alu_op);
  assign alu_src1 = shift ? rt_value :
                    alu_op[OP_LUI] ? {16'b0, imm} :
                    src1_is_pc ? pc : rs_value;
  assign alu_src2 = shift ? {27'b0, src1_is_sa ? imm[10:6] : rs_value[4:0]} :
                    src2_is_imm ? {{16{imm[15]}}, imm} :
                    src2_is_zimm ? {16'b0, imm} :
                    src2_is_8 ? 32'd8 : rt_value;
  alu u_alu (
    .alu_op    (alu_op),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .alu_result(alu_result)
  );
  always_comb begin
    es_to_ms_bus = '0;
    es_to_ms_bus[MS_MEM_RE] = mem_re;
    es_to_ms_bus[MS_GR_WE] = gr_we;
    es_to_ms_bus[MS_DEST_LSB +: 5] = dest;
    es_to_ms_bus[MS_RESULT_LSB +: 32] = alu_result;
    es_to_ms_bus[MS_PC_LSB +: 32] = pc;
  end
  assign data_sram_en = es_valid && ms_allowin && !es_flush && (mem_re || mem_we);
  assign data_sram_wen = (data_sram_en && mem_we) ? 4'hF : 4'h0;
  assign data_sram_addr = alu_result;
  assign data_sram_wdata = rt_value;
`ifdef ES_FWD_EN
  always_comb begin
    es_fwd_bus = '0;
    es_fwd_bus[FWD_WR_VALID] = es_valid && gr_we && (dest != 5'd0);
    es_fwd_bus[FWD_IS_LOAD] = es_valid && mem_re;
    es_fwd_bus[FWD_DEST_LSB +: 5] = dest;
    es_fwd_bus[FWD_RESULT_LSB +: 32] = alu_result;
  end
`endif
endmodule
